// File: rtl/pic_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pic_fetch_unit_if
// Bundles the signals between the fetch unit, the combinational program ROM
// and the decode/ALU datapath.
//   master : the fetch unit. It drives the ROM address, IR, RETLW load and
//            stack flags, and receives the ROM word, stall and skip.
//   slave  : the ROM and datapath side of the same signals.
// Signals:
//   rom_addr_out  address to program ROM (equals the PC register)
//   rom_data_in   ROM word for rom_addr_out, valid in the same cycle
//   stall_in      freeze PC, IR and stack for this cycle
//   skip_in       instruction in IR resolved as a skip
//   ir_out        instruction register for the execute stage
//   ir_pc_out     address the IR word was fetched from
//   w_load_out    IR holds RETLW; datapath loads W
//   w_data_out    RETLW literal
//   stack_ovf_out sticky flag: push with a full stack
//   stack_unf_out sticky flag: pop with an empty stack
// ---------------------------------------------------------------------------
interface pic_fetch_unit_if #(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 14
);
  logic [ADDR_W-1:0]  rom_addr_out;
  logic [INSTR_W-1:0] rom_data_in;
  logic               stall_in;
  logic               skip_in;
  logic [INSTR_W-1:0] ir_out;
  logic [ADDR_W-1:0]  ir_pc_out;
  logic               w_load_out;
  logic [7:0]         w_data_out;
  logic               stack_ovf_out;
  logic               stack_unf_out;

  modport master (
    output rom_addr_out,
    input  rom_data_in,
    input  stall_in,
    input  skip_in,
    output ir_out,
    output ir_pc_out,
    output w_load_out,
    output w_data_out,
    output stack_ovf_out,
    output stack_unf_out
  );

  modport slave (
    input  rom_addr_out,
    output rom_data_in,
    output stall_in,
    output skip_in,
    input  ir_out,
    input  ir_pc_out,
    input  w_load_out,
    input  w_data_out,
    input  stack_ovf_out,
    input  stack_unf_out
  );
endinterface

// File: rtl/pic_fetch_unit.sv
// ---------------------------------------------------------------------------
// pic_fetch_unit
// Instruction fetch and program-counter front end for the 14-bit, 2K-word
// core. It drives the address of the combinational program ROM, captures the
// returned word into the instruction register one clock later, and handles
// GOTO / CALL / RETURN / RETLW sequencing with an 8-level circular return
// stack. Taken control flow and skips flush the fetched word into a NOP.
// Ports:
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   pic_fetch_unit_if master modport (ROM bus, IR, RETLW, stack flags)
// ---------------------------------------------------------------------------
module pic_fetch_unit #(
  parameter int                ADDR_W       = 11,
  parameter int                INSTR_W      = 14,
  parameter int                STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 11'h000
) (
  input  logic clk,
  input  logic rst_n,
  pic_fetch_unit_if.master bus
);

  localparam int SP_W    = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  localparam logic [INSTR_W-1:0] NOP_WORD    = '0;
  localparam logic [INSTR_W-1:0] RETURN_WORD = INSTR_W'(14'h0008);
  localparam logic [DEPTH_W-1:0] DEPTH_FULL  = DEPTH_W'(STACK_DEPTH);

  // State
  logic [ADDR_W-1:0]  pc_reg,    pc_next;
  logic [INSTR_W-1:0] ir_reg,    ir_next;
  logic [ADDR_W-1:0]  ir_pc_reg, ir_pc_next;
  logic [SP_W-1:0]    sp_reg,    sp_next;
  logic [DEPTH_W-1:0] depth_reg, depth_next;
  logic               ovf_reg,   ovf_next;
  logic               unf_reg,   unf_next;

  // sp_reg points at the next free slot; the top of stack is sp_reg-1.
  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

  // Decode of the word currently in IR
  logic              is_goto;
  logic              is_call;
  logic              is_return;
  logic              is_retlw;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc_inc;
  logic [SP_W-1:0]   sp_pop;
  logic [ADDR_W-1:0] pop_addr;
  logic              push_en;

  assign is_goto       = (ir_reg[13:11] == 3'b101);
  assign is_call       = (ir_reg[13:11] == 3'b100);
  assign is_return     = (ir_reg == RETURN_WORD);
  assign is_retlw      = (ir_reg[13:10] == 4'b1101);
  assign branch_target = ir_reg[ADDR_W-1:0];
  assign pc_inc        = pc_reg + ADDR_W'(1);
  assign sp_pop        = sp_reg - SP_W'(1);
  assign pop_addr      = stack_mem[sp_pop];

  // Next-state logic. Control flow is decided only by IR; a flushed IR is a
  // NOP, so the word discarded after a branch can never act on its own.
  always_comb begin
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    ir_pc_next = ir_pc_reg;
    sp_next    = sp_reg;
    depth_next = depth_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    push_en    = 1'b0;

    if (!bus.stall_in) begin
      if (is_goto) begin
        pc_next = branch_target;
        ir_next = NOP_WORD;
      end else if (is_call) begin
        // PC already holds call address + 1, which is the return address.
        push_en = 1'b1;
        sp_next = sp_reg + SP_W'(1);
        if (depth_reg == DEPTH_FULL) begin
          // Circular stack: the slot at sp_reg is the oldest entry.
          ovf_next = 1'b1;
        end else begin
          depth_next = depth_reg + DEPTH_W'(1);
        end
        pc_next = branch_target;
        ir_next = NOP_WORD;
      end else if (is_return || is_retlw) begin
        pc_next = pop_addr;
        sp_next = sp_pop;
        if (depth_reg == '0) begin
          // Still pops the wrapped entry; only the sticky flag records it.
          unf_next = 1'b1;
        end else begin
          depth_next = depth_reg - DEPTH_W'(1);
        end
        ir_next = NOP_WORD;
      end else if (bus.skip_in) begin
        pc_next = pc_inc;
        ir_next = NOP_WORD;
      end else begin
        pc_next    = pc_inc;
        ir_next    = bus.rom_data_in;
        ir_pc_next = pc_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_VECTOR;
      ir_reg    <= NOP_WORD;
      ir_pc_reg <= '0;
      sp_reg    <= '0;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      ir_pc_reg <= ir_pc_next;
      sp_reg    <= sp_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Stack storage carries no reset: after reset depth is 0, so its contents
  // are only observable through an underflow pop. Writes are blocked while
  // rst_n is low so a push pending at reset assertion is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && push_en) begin
      stack_mem[sp_reg] <= pc_reg;
    end
  end

  // Outputs
  assign bus.rom_addr_out  = pc_reg;
  assign bus.ir_out        = ir_reg;
  assign bus.ir_pc_out     = ir_pc_reg;
  assign bus.w_load_out    = is_retlw;
  assign bus.w_data_out    = ir_reg[7:0];
  assign bus.stack_ovf_out = ovf_reg;
  assign bus.stack_unf_out = unf_reg;

endmodule

// File: tb/tb_pic_fetch_unit.sv
module tb_pic_fetch_unit;

  logic clk;
  logic rst_n;

  pic_fetch_unit_if #(.ADDR_W(11), .INSTR_W(14)) bus ();

  pic_fetch_unit #(
    .ADDR_W      (11),
    .INSTR_W     (14),
    .STACK_DEPTH (8),
    .RESET_VECTOR(11'h000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Combinational program ROM model
  logic [13:0] rom [2048];
  assign bus.rom_data_in = rom[bus.rom_addr_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic rom_fill();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h3001;
  endtask

  // Reset held across one rising edge, released away from the edge.
  task automatic do_reset();
    bus.stall_in = 1'b0;
    bus.skip_in  = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        skip;
    logic [10:0] addr;
    logic [13:0] ir;
    logic [10:0] irpc;
    logic        wload;
    logic [7:0]  wdata;
  } vec_t;

  vec_t vecs [23];

  initial begin
    rst_n        = 1'b0;
    bus.stall_in = 1'b0;
    bus.skip_in  = 1'b0;

    // ---------------- table-driven program run ----------------
    vecs[0]  = '{1'b0, 1'b0, 11'h000, 14'h0000, 11'h000, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 11'h001, 14'h3001, 11'h000, 1'b0, 8'h01};
    vecs[2]  = '{1'b0, 1'b0, 11'h002, 14'h3001, 11'h001, 1'b0, 8'h01};
    vecs[3]  = '{1'b0, 1'b0, 11'h003, 14'h3001, 11'h002, 1'b0, 8'h01};
    vecs[4]  = '{1'b0, 1'b0, 11'h004, 14'h2805, 11'h003, 1'b0, 8'h05};
    vecs[5]  = '{1'b0, 1'b0, 11'h005, 14'h0000, 11'h003, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 11'h006, 14'h303C, 11'h005, 1'b0, 8'h3C};
    vecs[7]  = '{1'b0, 1'b0, 11'h007, 14'h2010, 11'h006, 1'b0, 8'h10};
    vecs[8]  = '{1'b0, 1'b0, 11'h010, 14'h0000, 11'h006, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 11'h011, 14'h0008, 11'h010, 1'b0, 8'h08};
    vecs[10] = '{1'b0, 1'b0, 11'h007, 14'h0000, 11'h010, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 11'h008, 14'h3001, 11'h007, 1'b0, 8'h01};
    vecs[12] = '{1'b0, 1'b0, 11'h009, 14'h2020, 11'h008, 1'b0, 8'h20};
    vecs[13] = '{1'b0, 1'b0, 11'h020, 14'h0000, 11'h008, 1'b0, 8'h00};
    vecs[14] = '{1'b0, 1'b0, 11'h021, 14'h3455, 11'h020, 1'b1, 8'h55};
    vecs[15] = '{1'b0, 1'b0, 11'h009, 14'h0000, 11'h020, 1'b0, 8'h00};
    vecs[16] = '{1'b0, 1'b1, 11'h00A, 14'h0BA4, 11'h009, 1'b0, 8'hA4};
    vecs[17] = '{1'b0, 1'b0, 11'h00B, 14'h0000, 11'h009, 1'b0, 8'h00};
    vecs[18] = '{1'b0, 1'b0, 11'h00C, 14'h3001, 11'h00B, 1'b0, 8'h01};
    vecs[19] = '{1'b0, 1'b1, 11'h00D, 14'h2830, 11'h00C, 1'b0, 8'h30};
    vecs[20] = '{1'b1, 1'b0, 11'h030, 14'h0000, 11'h00C, 1'b0, 8'h00};
    vecs[21] = '{1'b0, 1'b0, 11'h030, 14'h0000, 11'h00C, 1'b0, 8'h00};
    vecs[22] = '{1'b0, 1'b0, 11'h031, 14'h3001, 11'h030, 1'b0, 8'h01};

    rom_fill();
    rom[11'h003] = 14'h2805;  // GOTO 5
    rom[11'h004] = 14'h2010;  // flushed, never executed
    rom[11'h005] = 14'h303C;
    rom[11'h006] = 14'h2010;  // CALL 0x10
    rom[11'h008] = 14'h2020;  // CALL 0x20
    rom[11'h009] = 14'h0BA4;  // skip-type instruction
    rom[11'h00A] = 14'h2805;  // skipped GOTO, must be flushed
    rom[11'h00C] = 14'h2830;  // GOTO 0x30 (skip_in ignored)
    rom[11'h010] = 14'h0008;  // RETURN
    rom[11'h020] = 14'h3455;  // RETLW 0x55

    do_reset();
    for (int r = 0; r < 23; r++) begin
      bus.stall_in = vecs[r].stall;
      bus.skip_in  = vecs[r].skip;
      $display("row %0d addr=%h ir=%h irpc=%h wl=%b wd=%h", r, bus.rom_addr_out,
               bus.ir_out, bus.ir_pc_out, bus.w_load_out, bus.w_data_out);
      chk($sformatf("row%0d_addr", r),  32'(bus.rom_addr_out),  32'(vecs[r].addr));
      chk($sformatf("row%0d_ir", r),    32'(bus.ir_out),        32'(vecs[r].ir));
      chk($sformatf("row%0d_irpc", r),  32'(bus.ir_pc_out),     32'(vecs[r].irpc));
      chk($sformatf("row%0d_wload", r), 32'(bus.w_load_out),    32'(vecs[r].wload));
      chk($sformatf("row%0d_wdata", r), 32'(bus.w_data_out),    32'(vecs[r].wdata));
      chk($sformatf("row%0d_ovf", r),   32'(bus.stack_ovf_out), 32'(1'b0));
      chk($sformatf("row%0d_unf", r),   32'(bus.stack_unf_out), 32'(1'b0));
      step();
    end
    bus.stall_in = 1'b0;
    bus.skip_in  = 1'b0;

    // ---------------- stalled GOTO and PC wrap ----------------
    rom_fill();
    rom[11'h001] = 14'h2FFF;  // GOTO 0x7FF
    do_reset();
    step();
    step();
    chk("stall_pre_ir", 32'(bus.ir_out), 32'(14'h2FFF));
    bus.stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      $display("stall cycle %0d addr=%h ir=%h", k, bus.rom_addr_out, bus.ir_out);
      chk($sformatf("stall%0d_addr", k), 32'(bus.rom_addr_out), 32'(11'h002));
      chk($sformatf("stall%0d_ir", k),   32'(bus.ir_out),       32'(14'h2FFF));
      chk($sformatf("stall%0d_irpc", k), 32'(bus.ir_pc_out),    32'(11'h001));
    end
    bus.stall_in = 1'b0;
    step();
    $display("stall release addr=%h ir=%h", bus.rom_addr_out, bus.ir_out);
    chk("release_addr", 32'(bus.rom_addr_out), 32'(11'h7FF));
    chk("release_ir",   32'(bus.ir_out),       32'(14'h0000));
    step();
    $display("wrap addr=%h ir=%h irpc=%h", bus.rom_addr_out, bus.ir_out, bus.ir_pc_out);
    chk("wrap_addr", 32'(bus.rom_addr_out), 32'(11'h000));
    chk("wrap_ir",   32'(bus.ir_out),       32'(14'h3001));
    chk("wrap_irpc", 32'(bus.ir_pc_out),    32'(11'h7FF));

    // ---------------- nested calls: overflow and underflow ----------------
    // Call 1 at 0 -> 0x110; call n (n>=2) at 0x100+0x10*(n-1) -> 0x100+0x10*n.
    // Each return address 0x101+0x10*k holds RETURN; 0x190 holds RETURN.
    rom_fill();
    rom[11'h000] = 14'h2110;
    for (int n = 1; n <= 8; n++) begin
      rom[11'(32'h100 + 32'h10 * n)]     = 14'h2000 | 14'(32'h100 + 32'h10 * (n + 1));
      rom[11'(32'h101 + 32'h10 * n)]     = 14'h0008;
    end
    rom[11'h190] = 14'h0008;
    do_reset();
    // CALL n executes on edge 2n.
    for (int n = 1; n <= 9; n++) begin
      step();
      step();
      $display("call %0d addr=%h ovf=%b", n, bus.rom_addr_out, bus.stack_ovf_out);
      chk($sformatf("call%0d_addr", n), 32'(bus.rom_addr_out), 32'h100 + 32'h10 * n);
      chk($sformatf("call%0d_ovf", n),  32'(bus.stack_ovf_out), (n == 9) ? 32'd1 : 32'd0);
    end
    // Returns 1..8 land on 0x181,0x171,...,0x111. Return 9 underflows and
    // pops the wrapped slot 0, which was overwritten by push 9 (0x181).
    // Return 10 then pops slot 7 (0x171).
    for (int j = 1; j <= 10; j++) begin
      logic [10:0] dest;
      if (j <= 8)      dest = 11'(32'h191 - 32'h10 * j);
      else if (j == 9) dest = 11'h181;
      else             dest = 11'h171;
      step();
      step();
      $display("return %0d addr=%h ovf=%b unf=%b", j, bus.rom_addr_out,
               bus.stack_ovf_out, bus.stack_unf_out);
      chk($sformatf("ret%0d_addr", j), 32'(bus.rom_addr_out), 32'(dest));
      chk($sformatf("ret%0d_unf", j),  32'(bus.stack_unf_out), (j >= 9) ? 32'd1 : 32'd0);
      chk($sformatf("ret%0d_ovf", j),  32'(bus.stack_ovf_out), 32'd1);
    end

    // ---------------- asynchronous reset during stall ----------------
    bus.stall_in = 1'b1;
    step();
    step();
    chk("pre_rst_addr", 32'(bus.rom_addr_out), 32'(11'h171));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("async reset addr=%h ir=%h ovf=%b unf=%b", bus.rom_addr_out, bus.ir_out,
             bus.stack_ovf_out, bus.stack_unf_out);
    chk("arst_addr",  32'(bus.rom_addr_out),  32'(11'h000));
    chk("arst_ir",    32'(bus.ir_out),        32'(14'h0000));
    chk("arst_irpc",  32'(bus.ir_pc_out),     32'(11'h000));
    chk("arst_ovf",   32'(bus.stack_ovf_out), 32'd0);
    chk("arst_unf",   32'(bus.stack_unf_out), 32'd0);
    chk("arst_wload", 32'(bus.w_load_out),    32'd0);
    bus.stall_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_addr", 32'(bus.rom_addr_out), 32'(11'h001));
    chk("post_rst_ir",   32'(bus.ir_out),       32'(14'h2110));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
